// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard front end: deserializes frames into scan codes and tags them with F0 (break) / E0 (extended) flags; PS2_KEY_HELD_EN adds held-key tracking.
// code_valid / frame_error fire 2 clocks after the stop-bit sample; there is no back-pressure, so a missed strobe loses the code.
module ps2_scan_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_kb_clock,
  input  logic       i_kb_data,
  output logic [7:0] o_raw_data,
  output logic       o_code_valid,
  output logic       o_key_released,
  output logic       o_extended,
  output logic       o_frame_error
`ifdef PS2_KEY_HELD_EN
  ,
  output logic [7:0] o_held_code,
  output logic       o_key_held
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_CHECK} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;
  logic                   w_dat_s;
  logic                   w_fall;
  logic [3:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_parity;
  logic                   r_stop;
  logic [TW-1:0]          r_tmo_cnt;
  logic                   r_brk_pend;
  logic                   r_ext_pend;
  logic [7:0]             r_raw_data;
  logic                   r_code_valid;
  logic                   r_key_released;
  logic                   r_extended;
  logic                   r_frame_error;
  logic                   w_frame_ok;
  logic                   w_timeout;
  logic                   w_emit;
  logic                   w_err;
  logic                   w_set_brk;
  logic                   w_set_ext;
  logic                   w_clr_pend;

  assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s    = r_dat_sync[SYNC_STAGES-1];
  assign w_fall     = r_clk_prev & ~w_clk_s;
  assign w_frame_ok = r_stop & (^r_shift ^ r_parity);
  assign w_timeout  = (r_tmo_cnt == TW'(TIMEOUT_CYCLES));

  // Synchronizers reset to the idle-high level so reset release cannot fake an edge.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_kb_clock};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_kb_data};
      r_clk_prev <= w_clk_s;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_err       = 1'b0;
    w_set_brk   = 1'b0;
    w_set_ext   = 1'b0;
    w_clr_pend  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall && !w_dat_s) w_state_nxt = ST_RECV;
      end
      ST_RECV: begin
        if (w_fall) begin
          if (r_bit_cnt == 4'd10) w_state_nxt = ST_CHECK;
        end else if (w_timeout) begin
          w_err       = 1'b1;
          w_clr_pend  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CHECK: begin
        w_state_nxt = ST_IDLE;
        if (!w_frame_ok) begin
          w_err      = 1'b1;
          w_clr_pend = 1'b1;
        end else if (r_shift == 8'hF0) begin
          w_set_brk = 1'b1;
        end else if (r_shift == 8'hE0) begin
          w_set_ext = 1'b1;
        end else begin
          w_emit     = 1'b1;
          w_clr_pend = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_parity       <= 1'b0;
      r_stop         <= 1'b0;
      r_tmo_cnt      <= '0;
      r_brk_pend     <= 1'b0;
      r_ext_pend     <= 1'b0;
      r_raw_data     <= '0;
      r_code_valid   <= 1'b0;
      r_key_released <= 1'b0;
      r_extended     <= 1'b0;
      r_frame_error  <= 1'b0;
    end else begin
      r_code_valid  <= w_emit;
      r_frame_error <= w_err;
      if (w_emit) begin
        r_raw_data     <= r_shift;
        r_key_released <= r_brk_pend;
        r_extended     <= r_ext_pend;
      end
      if (w_clr_pend) begin
        r_brk_pend <= 1'b0;
        r_ext_pend <= 1'b0;
      end else begin
        if (w_set_brk) r_brk_pend <= 1'b1;
        if (w_set_ext) r_ext_pend <= 1'b1;
      end
      if (r_state == ST_IDLE) begin
        if (w_fall && !w_dat_s) begin
          r_bit_cnt <= 4'd1;
          r_tmo_cnt <= '0;
        end
      end else if (r_state == ST_RECV) begin
        if (w_fall) begin
          r_tmo_cnt <= '0;
          r_bit_cnt <= r_bit_cnt + 4'd1;
          // LSB arrives first, so after eight shifts d0 sits in bit 0.
          if (r_bit_cnt <= 4'd8)      r_shift  <= {w_dat_s, r_shift[7:1]};
          else if (r_bit_cnt == 4'd9) r_parity <= w_dat_s;
          else                        r_stop   <= w_dat_s;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
      end
    end
  end

  assign o_raw_data     = r_raw_data;
  assign o_code_valid   = r_code_valid;
  assign o_key_released = r_key_released;
  assign o_extended     = r_extended;
  assign o_frame_error  = r_frame_error;

`ifdef PS2_KEY_HELD_EN
  logic [7:0] r_held_code;
  logic       r_key_held;

  // Extended codes never touch the held-key state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_held_code <= '0;
      r_key_held  <= 1'b0;
    end else if (w_emit && !r_ext_pend) begin
      if (!r_brk_pend) begin
        r_held_code <= r_shift;
        r_key_held  <= 1'b1;
      end else if (r_shift == r_held_code) begin
        r_key_held <= 1'b0;
      end
    end
  end

  assign o_held_code = r_held_code;
  assign o_key_held  = r_key_held;
`endif

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Bench for ps2_scan_receiver: directed scenarios plus a randomized frame stream scored against a prefix-level model.
module tb_ps2_scan_receiver;
  localparam int SYNC = 2;
  localparam int TMO  = 200;
  localparam int HALF = 20;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       kb_clock = 1'b1;
  logic       kb_data  = 1'b1;
  logic [7:0] raw_data;
  logic       code_valid, key_released, extended, frame_error;
`ifdef PS2_KEY_HELD_EN
  logic [7:0] held_code;
  logic       key_held;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  ps2_scan_receiver #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clock(clk), .i_reset(reset), .i_kb_clock(kb_clock), .i_kb_data(kb_data),
    .o_raw_data(raw_data), .o_code_valid(code_valid), .o_key_released(key_released),
    .o_extended(extended), .o_frame_error(frame_error)
`ifdef PS2_KEY_HELD_EN
    , .o_held_code(held_code), .o_key_held(key_held)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] raw; logic rel; logic ext; } code_t;
  code_t evq[$];
  int    evlat[$];
  int    err_cnt   = 0;
  int    err_lat   = 0;
  int    cyc       = 0;
  int    last_fall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && code_valid) begin
      evq.push_back({raw_data, key_released, extended});
      evlat.push_back(cyc - last_fall);
    end
    if (!reset && frame_error) begin
      err_cnt <= err_cnt + 1;
      err_lat <= cyc - last_fall;
    end
  end

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); kb_data = bits[i];
      repeat (HALF) @(negedge clk);
      kb_clock = 1'b0; last_fall = cyc;
      repeat (HALF) @(negedge clk);
      kb_clock = 1'b1;
    end
    @(negedge clk); kb_data = 1'b1;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bits({1'b1, ~(^b) ^ bad_par, b, 1'b0}, 11);
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (raw_data !== 8'h00) $display("FAIL reset_raw: got %h want 00", raw_data); else n_pass++;
    n_checks++; if ({code_valid, key_released, extended, frame_error} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000", {code_valid, key_released, extended, frame_error}); else n_pass++;
`ifdef PS2_KEY_HELD_EN
    n_checks++; if ({held_code, key_held} !== 9'h0) $display("FAIL reset_held: got %h want 000", {held_code, key_held}); else n_pass++;
`endif
  endtask

  task automatic test_basic();
    int q0 = evq.size();
    int e0 = err_cnt;
    int lat;
    send_frame(8'h1C, 1'b0);
    lat = (evlat.size() > q0) ? evlat[q0] : -1;
    n_checks++; if (evq.size() - q0 !== 1) $display("FAIL basic_strobes: got %0d want 1", evq.size() - q0); else n_pass++;
    n_checks++; if (raw_data !== 8'h1C) $display("FAIL basic_raw: got %h want 1c", raw_data); else n_pass++;
    n_checks++; if ({key_released, extended} !== 2'b00) $display("FAIL basic_flags: got %b want 00", {key_released, extended}); else n_pass++;
    n_checks++; if (lat !== SYNC + 2) $display("FAIL basic_latency: got %0d want %0d", lat, SYNC + 2); else n_pass++;
    n_checks++; if (err_cnt - e0 !== 0) $display("FAIL basic_err: got %0d want 0", err_cnt - e0); else n_pass++;
  endtask

  task automatic test_break();
    int q0 = evq.size();
    send_frame(8'hF0, 1'b0);
    n_checks++; if (evq.size() - q0 !== 0) $display("FAIL break_prefix_strobe: got %0d want 0", evq.size() - q0); else n_pass++;
    send_frame(8'h1C, 1'b0);
    n_checks++; if (evq.size() - q0 !== 1) $display("FAIL break_strobes: got %0d want 1", evq.size() - q0); else n_pass++;
    n_checks++; if ({raw_data, key_released, extended} !== {8'h1C, 2'b10})
      $display("FAIL break_code: got %h/%b%b want 1c/10", raw_data, key_released, extended); else n_pass++;
    send_frame(8'h23, 1'b0);
    n_checks++; if ({raw_data, key_released} !== {8'h23, 1'b0})
      $display("FAIL make_after_break: got %h/%b want 23/0", raw_data, key_released); else n_pass++;
  endtask

  task automatic test_ext_break();
    int q0 = evq.size();
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    n_checks++; if (evq.size() - q0 !== 1) $display("FAIL ext_strobes: got %0d want 1", evq.size() - q0); else n_pass++;
    n_checks++; if ({raw_data, key_released, extended} !== {8'h75, 2'b11})
      $display("FAIL ext_code: got %h/%b%b want 75/11", raw_data, key_released, extended); else n_pass++;
  endtask

  task automatic test_parity();
    int q0 = evq.size();
    int e0 = err_cnt;
    send_frame(8'h1C, 1'b1);
    n_checks++; if (err_cnt - e0 !== 1) $display("FAIL parity_err: got %0d want 1", err_cnt - e0); else n_pass++;
    n_checks++; if (evq.size() - q0 !== 0) $display("FAIL parity_strobe: got %0d want 0", evq.size() - q0); else n_pass++;
    n_checks++; if (raw_data !== 8'h75) $display("FAIL parity_hold: got %h want 75", raw_data); else n_pass++;
    send_frame(8'h24, 1'b0);
    n_checks++; if ({raw_data, key_released, extended} !== {8'h24, 2'b00})
      $display("FAIL parity_recover: got %h/%b%b want 24/00", raw_data, key_released, extended); else n_pass++;
  endtask

  task automatic test_timeout();
    int q0 = evq.size();
    int e0 = err_cnt;
    send_bits({6'b0, 4'b1010, 1'b0}, 5);
    repeat (TMO + 20) @(negedge clk);
    n_checks++; if (err_cnt - e0 !== 1) $display("FAIL timeout_err: got %0d want 1", err_cnt - e0); else n_pass++;
    n_checks++; if (err_lat < TMO || err_lat > TMO + SYNC + 4)
      $display("FAIL timeout_when: got %0d want %0d..%0d", err_lat, TMO, TMO + SYNC + 4); else n_pass++;
    n_checks++; if (evq.size() - q0 !== 0) $display("FAIL timeout_strobe: got %0d want 0", evq.size() - q0); else n_pass++;
    send_frame(8'h2B, 1'b0);
    n_checks++; if (raw_data !== 8'h2B) $display("FAIL timeout_recover: got %h want 2b", raw_data); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int q0;
    int e0;
    send_bits({4'b0, 6'b110101, 1'b0}, 7);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    q0 = evq.size();
    e0 = err_cnt;
    n_checks++; if ({raw_data, code_valid, key_released, extended, frame_error} !== 12'h0)
      $display("FAIL midreset_outputs: got %h want 000", {raw_data, code_valid, key_released, extended, frame_error}); else n_pass++;
`ifdef PS2_KEY_HELD_EN
    n_checks++; if ({held_code, key_held} !== 9'h0) $display("FAIL midreset_held: got %h want 000", {held_code, key_held}); else n_pass++;
`endif
    repeat (TMO + 20) @(negedge clk);
    n_checks++; if ((evq.size() - q0) + (err_cnt - e0) !== 0)
      $display("FAIL midreset_quiet: got %0d events want 0", (evq.size() - q0) + (err_cnt - e0)); else n_pass++;
  endtask

`ifdef PS2_KEY_HELD_EN
  task automatic test_held();
    send_frame(8'h15, 1'b0);
    n_checks++; if ({held_code, key_held} !== {8'h15, 1'b1}) $display("FAIL held_make: got %h/%b want 15/1", held_code, key_held); else n_pass++;
    send_frame(8'h15, 1'b0);
    n_checks++; if ({held_code, key_held} !== {8'h15, 1'b1}) $display("FAIL held_repeat: got %h/%b want 15/1", held_code, key_held); else n_pass++;
    send_frame(8'hF0, 1'b0); send_frame(8'h1D, 1'b0);
    n_checks++; if ({held_code, key_held} !== {8'h15, 1'b1}) $display("FAIL held_other_break: got %h/%b want 15/1", held_code, key_held); else n_pass++;
    send_frame(8'hF0, 1'b0); send_frame(8'h15, 1'b0);
    n_checks++; if ({held_code, key_held} !== {8'h15, 1'b0}) $display("FAIL held_release: got %h/%b want 15/0", held_code, key_held); else n_pass++;
  endtask
`endif

  // Model: a frame is either bad (error, prefixes dropped), a prefix byte, or a code carrying the pending prefixes.
  task automatic test_random();
    code_t      exq[$];
    int         q0 = evq.size();
    int         e0 = err_cnt;
    int         exp_err = 0;
    logic       m_brk = 1'b0, m_ext = 1'b0;
    logic [7:0] m_held = 8'h00;
    logic       m_kh = 1'b0;
    code_t      got;
`ifdef PS2_KEY_HELD_EN
    m_held = held_code;
    m_kh   = key_held;
`endif
    for (int f = 0; f < 16; f++) begin
      int         r   = $urandom_range(0, 11);
      logic [7:0] b   = (r < 2) ? 8'hF0 : (r == 2) ? 8'hE0 : 8'($urandom_range(0, 255));
      logic       bad = ($urandom_range(0, 7) == 0);
      send_frame(b, bad);
      if (bad) begin
        exp_err++; m_brk = 1'b0; m_ext = 1'b0;
      end else if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE0) m_ext = 1'b1;
      else begin
        exq.push_back({b, m_brk, m_ext});
        if (!m_ext && !m_brk) begin m_held = b; m_kh = 1'b1; end
        else if (!m_ext && b == m_held) m_kh = 1'b0;
        m_brk = 1'b0; m_ext = 1'b0;
      end
    end
    n_checks++; if (evq.size() - q0 !== exq.size())
      $display("FAIL rand_strobes: got %0d want %0d", evq.size() - q0, exq.size()); else n_pass++;
    n_checks++; if (err_cnt - e0 !== exp_err) $display("FAIL rand_errors: got %0d want %0d", err_cnt - e0, exp_err); else n_pass++;
    for (int i = 0; i < exq.size(); i++) begin
      got = (q0 + i < evq.size()) ? evq[q0 + i] : 10'h3FF;
      n_checks++; if (got !== exq[i]) $display("FAIL rand_code%0d: got %h want %h", i, got, exq[i]); else n_pass++;
    end
`ifdef PS2_KEY_HELD_EN
    n_checks++; if ({held_code, key_held} !== {m_held, m_kh})
      $display("FAIL rand_held: got %h/%b want %h/%b", held_code, key_held, m_held, m_kh); else n_pass++;
`else
    if (m_kh && m_held == 8'h00) m_kh = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_break();
    test_ext_break();
    test_parity();
    test_timeout();
    test_reset_mid();
`ifdef PS2_KEY_HELD_EN
    test_held();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_scan_receiver.md
Name: ps2_scan_receiver

Overview:
- Front-end stage of the keyboard path. Deserializes PS/2 frames from the kb_clock/kb_data pins into 8-bit scan codes, running in the system clock domain.
- Strips the 0xF0 (break) and 0xE0 (extended) prefixes and tags the following code with flags.
- Drives raw_data[7:0] of the scan-code-to-ASCII converter, plus a one-cycle code_valid strobe for the recorder logic.

Parameters:
- SYNC_STAGES, 2: flop depth of the kb_clock/kb_data synchronizers (minimum 2).
- TIMEOUT_CYCLES, 10000: max system clocks allowed between kb_clock falling edges inside a frame (200 us at 50 MHz).

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- kb_clock  in  1  raw PS/2 clock pin; asynchronous, idle high.
- kb_data  in  1  raw PS/2 data pin; asynchronous, idle high.
- raw_data  out  8  last accepted scan code, prefixes removed.
- code_valid  out  1  one-cycle pulse when raw_data/key_released/extended update.
- key_released  out  1  1 = raw_data was preceded by 0xF0.
- extended  out  1  1 = raw_data was preceded by 0xE0.
- frame_error  out  1  one-cycle pulse on a bad stop bit, bad parity or timeout.
- held_code  out  8  only with KEY_HELD_EN.
- key_held  out  1  only with KEY_HELD_EN.

Behaviour:
- Reset (synchronous, active-high): every output is 0, the FSM returns to IDLE, and all counters and pending flags clear. Reset mid-frame discards the partial frame; reception restarts at the next start bit.
- Input sync: kb_clock and kb_data each pass through SYNC_STAGES flops.
- Falling edge: a falling edge is previous synced clock = 1 and current = 0. On that cycle, synced data is sampled.
- Frame format: 11 bits, LSB first: start (0), d0..d7, odd parity, stop (1).
- FSM IDLE:
  - On a falling edge with data = 0, go to RECV, bit_cnt = 1, clear the timeout counter.
  - On a falling edge with data = 1, treat it as a glitch: stay in IDLE, no error.
- FSM RECV:
  - Each falling edge shifts data into shift_reg[bit_cnt-1] for bit_cnt 1..8. Bit_cnt 9 is parity; bit_cnt 10 is stop. Bit_cnt increments per edge.
  - The timeout counter resets on every edge and otherwise increments.
  - If the counter reaches TIMEOUT_CYCLES, pulse frame_error, go to IDLE and clear the pending flags.
  - After the stop-bit edge, go to CHECK.
- FSM CHECK (exactly one cycle):
  - Frame is valid when stop = 1 and XOR(d0..d7, parity) = 1.
  - Invalid frame: pulse frame_error, clear the pending flags, keep the outputs, go to IDLE.
  - Valid byte 0xF0: set brk_pend, no strobe.
  - Valid byte 0xE0: set ext_pend, no strobe.
  - Any other valid byte, on the next cycle:
    - raw_data = byte, key_released = brk_pend, extended = ext_pend.
    - code_valid = 1 for one cycle.
    - Both pending flags clear.
  - Go to IDLE.
- Latency: code_valid is high exactly 2 system clocks after the cycle the stop bit is sampled.
- Hold: raw_data, key_released and extended hold their values until the next strobe.
- Prefix order: E0 then F0 gives extended = 1 and key_released = 1. Repeated prefixes are idempotent.
- No back-pressure. A code is overwritten if the consumer misses the strobe.
- Edges arriving during the CHECK cycle are ignored. This cannot occur in spec-compliant PS/2 timing.

Optional Feature:
- Macro: PS2_KEY_HELD_EN.
- With the macro defined, held_code and key_held exist, both reset to 0, and update on the cycle code_valid pulses:
  - Make code with extended = 0: held_code = raw_data, key_held = 1. Typematic repeats of the same code leave it at 1.
  - Break code equal to held_code: key_held = 0; held_code retains its value.
  - Break of a different code, or any extended code: no change.
- Without the macro, both ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Send frame 0x1C (parity 0, stop 1) at 12.5 kHz -> one code_valid pulse, raw_data = 0x1C, key_released = 0, extended = 0, frame_error never asserted.
- Send 0xF0 then 0x1C -> exactly one code_valid pulse, after the second frame, with raw_data = 0x1C and key_released = 1. Next a lone 0x23 -> key_released = 0.
- Send 0xE0, 0xF0, 0x75 -> single strobe, raw_data = 0x75, extended = 1, key_released = 1.
- Send 0x1C with the parity bit flipped -> frame_error pulses once, no code_valid, raw_data unchanged. A following good 0x24 decodes normally.
- Send the start bit plus 4 data bits, then hold kb_clock high for TIMEOUT_CYCLES + 5 -> frame_error at cycle TIMEOUT_CYCLES. A subsequent full 0x2B frame gives raw_data = 0x2B.
- Assert reset for 1 cycle mid-frame (after bit 6) -> all outputs 0, no strobe. With PS2_KEY_HELD_EN:
  - Make 0x15 -> key_held = 1, held_code = 0x15.
  - Make 0x15 again -> still 1.
  - F0 1D -> still 1.
  - F0 15 -> key_held = 0.
